// File: rtl/m_function_main.sv
// M-sequence generator: a prescaler divides the board clock down to the bit rate,
// and a Fibonacci LFSR advances once per bit period to drive the serial output.
module m_function_main #(
    parameter int unsigned      DIV   = 50,
    parameter int unsigned      WIDTH = 7,
    parameter logic [WIDTH-1:0] TAPS  = 7'b1100000,
    parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic CLK_50MHZ,
    input  logic RESET,
    output logic out_fun
);

    // Keep the counter at least one bit wide so DIV=1 still elaborates.
    localparam int unsigned     CntW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);
    localparam logic [WIDTH-1:0] One   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [CntW-1:0]  cnt;
    logic [WIDTH-1:0] s;
    logic             tick;
    logic             f;

    assign tick = (cnt == CntMax);
    assign f    = ^(s & TAPS);

    always_ff @(posedge CLK_50MHZ or posedge RESET) begin
        if (RESET) begin
            cnt <= '0;
            s   <= SEED;
        end else begin
            cnt <= tick ? '0 : cnt + CntW'(1);
            if (tick) begin
                // All-zero is a lock-up state for an XOR LFSR; kick it back onto the sequence.
                s <= (s == '0) ? One : {s[WIDTH-2:0], f};
            end
        end
    end

    assign out_fun = s[WIDTH-1];

endmodule

// File: tb/tb_m_function_main.sv
// Bench for m_function_main: DIV=1, DIV=50 and SEED=0 instances share a clock and reset,
// with a reference LFSR feeding scoreboard queues that are drained as outputs are sampled.
module tb_m_function_main;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic out1, out50, out0;

    always #5 clk = ~clk;

    m_function_main #(.DIV(1)) d1 (
        .CLK_50MHZ(clk), .RESET(rst), .out_fun(out1)
    );
    m_function_main #(.DIV(50)) d50 (
        .CLK_50MHZ(clk), .RESET(rst), .out_fun(out50)
    );
    m_function_main #(.DIV(1), .SEED(7'd0)) d0 (
        .CLK_50MHZ(clk), .RESET(rst), .out_fun(out0)
    );

    int tests = 0;
    int fails = 0;

    logic q1[$];
    logic q0[$];
    logic q50[$];
    logic cap[254];
    logic [7:0] first8;

    // x^7 + x^6 + 1, with the all-zero escape to 0000001.
    function automatic logic [6:0] ref_next(input logic [6:0] st);
        if (st == 7'd0) return 7'd1;
        return {st[5:0], st[6] ^ st[5]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic obs, inout logic q[$]);
        logic e;
        if (q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s: observed %0b expected queued value (queue empty)", tag, obs);
        end else begin
            e = q.pop_front();
            check(tag, {31'd0, obs}, {31'd0, e});
        end
    endtask

    initial begin
        logic [6:0] m1, m0, m50;
        int first_ret, ones, mism, run, max1, max0, found;
        logic prev;

        first8 = 8'b0100_0000;  // bit i = value i: 0,0,0,0,0,0,1,0
        repeat (3) @(negedge clk);
        check("reset_out1", {31'd0, out1}, 32'd0);
        check("reset_state1", {25'd0, d1.s}, 32'd1);
        check("reset_state0", {25'd0, d0.s}, 32'd0);
        check("reset_out0", {31'd0, out0}, 32'd0);
        check("reset_cnt50", {26'd0, d50.cnt}, 32'd0);

        // DIV=1 run: 254 bits from the default instance and the SEED=0 instance.
        rst = 1'b0;
        m1 = 7'd1;
        m0 = 7'd0;
        first_ret = -1;
        q1.push_back(m1[6]);
        q0.push_back(m0[6]);
        #1;
        pop_check("seq_div1", out1, q1);
        pop_check("seq_seed0", out0, q0);
        cap[0] = out1;
        for (int i = 1; i < 254; i++) begin
            @(posedge clk);
            m1 = ref_next(m1);
            m0 = ref_next(m0);
            q1.push_back(m1[6]);
            q0.push_back(m0[6]);
            @(negedge clk);
            pop_check("seq_div1", out1, q1);
            pop_check("seq_seed0", out0, q0);
            cap[i] = out1;
            if (d1.s == 7'd1 && first_ret < 0) first_ret = i;
            if (i == 1) check("seed0_first_tick", {25'd0, d0.s}, 32'd1);
        end
        for (int i = 0; i < 8; i++) check("first8", {31'd0, cap[i]}, {31'd0, first8[i]});

        mism = 0;
        ones = 0;
        for (int i = 0; i < 127; i++) begin
            if (cap[i] !== cap[i+127]) mism++;
            if (cap[i] === 1'b1) ones++;
        end
        check("period_repeat", mism, 0);
        check("period_ones", ones, 64);
        check("state_return", first_ret, 127);

        max1 = 0; max0 = 0; run = 0; prev = 1'bx;
        for (int i = 0; i < 254; i++) begin
            run = (cap[i] === prev) ? run + 1 : 1;
            prev = cap[i];
            if (prev === 1'b1 && run > max1) max1 = run;
            if (prev === 1'b0 && run > max0) max0 = run;
        end
        check("max_run_ones", max1, 7);
        check("max_run_zeros", max0, 6);

        // Asynchronous reset while the output is high, with no clock edge in between.
        found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (out1 === 1'b1) found = 1;
            else @(negedge clk);
        end
        check("find_high_bit", found, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out", {31'd0, out1}, 32'd0);
        check("async_rst_state", {25'd0, d1.s}, 32'd1);

        // DIV=50 run up to tick 40 + 17 cycles.
        @(negedge clk);
        rst = 1'b0;
        m50 = 7'd1;
        q50.push_back(m50[6]);
        #1;
        pop_check("seq_div50", out50, q50);
        for (int e = 1; e <= 2017; e++) begin
            @(posedge clk);
            if (e % 50 == 0) m50 = ref_next(m50);
            q50.push_back(m50[6]);
            @(negedge clk);
            pop_check("seq_div50", out50, q50);
            if (e == 299) check("div50_edge299", {31'd0, out50}, 32'd0);
            if (e == 300) check("div50_edge300", {31'd0, out50}, 32'd1);
            if (e == 349) check("div50_edge349", {31'd0, out50}, 32'd1);
            if (e == 350) check("div50_edge350", {31'd0, out50}, 32'd0);
            if (e == 49) check("div50_cnt49", {26'd0, d50.cnt}, 32'd49);
        end

        #2 rst = 1'b1;
        #1;
        check("midrun_rst_out", {31'd0, out50}, 32'd0);
        check("midrun_rst_cnt", {26'd0, d50.cnt}, 32'd0);
        check("midrun_rst_state", {25'd0, d50.s}, 32'd1);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("restart_bit", {31'd0, out50}, {31'd0, first8[0]});
        for (int e = 1; e < 400; e++) begin
            @(negedge clk);
            check("restart_bit", {31'd0, out50}, {31'd0, first8[e/50]});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
